wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_master.sv | 144 ++++++++++++++
 tb/tb_wb_cmd_master.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - command-word driven Wishbone pipelined bus master
// Executes one read/write/set-address/special command at a time and returns a single response word.
module wb_cmd_master #(
    parameter logic [31:0] ADDR_INC       = 32'd1,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_stb,
    input  logic [33:0] i_cmd_word,
    output logic        o_cmd_busy,
    output logic        o_overrun,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data,
    output logic        o_rsp_stb,
    output logic [33:0] o_rsp_word
);
    localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_SETA  = 2'b10;

    typedef enum logic [1:0] {IDLE, BUS_REQ, BUS_WAIT, RESP} state_t;

    state_t        state_q;
    logic [31:0]   addr_q;
    logic [TW-1:0] timer_q;
    logic          wb_cyc_q, wb_stb_q, wb_we_q;
    logic [31:0]   wb_addr_q, wb_data_q;
    logic          rsp_stb_q, overrun_q;
    logic [33:0]   rsp_word_q;

    logic [31:0]   addr_d;
    logic [TW-1:0] timer_d;
    logic [1:0]    cmd;
    logic          timed_out;

    assign cmd       = i_cmd_word[33:32];
    assign addr_d    = addr_q + ADDR_INC;
    assign timer_d   = timer_q + TW'(1);
    assign timed_out = (timer_q == TLAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            timer_q    <= '0;
            wb_cyc_q   <= 1'b0;
            wb_stb_q   <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            rsp_stb_q  <= 1'b0;
            overrun_q  <= 1'b0;
            rsp_word_q <= '0;
        end else begin
            overrun_q <= i_cmd_stb && (state_q != IDLE);
            rsp_stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_cmd_stb) begin
                        if (cmd == CMD_READ || cmd == CMD_WRITE) begin
                            state_q   <= BUS_REQ;
                            timer_q   <= '0;
                            wb_cyc_q  <= 1'b1;
                            wb_stb_q  <= 1'b1;
                            wb_we_q   <= (cmd == CMD_WRITE);
                            wb_addr_q <= addr_q;
                            wb_data_q <= (cmd == CMD_WRITE) ? i_cmd_word[31:0] : 32'h0;
                        end else if (cmd == CMD_SETA) begin
                            state_q    <= RESP;
                            addr_q     <= i_cmd_word[31:0];
                            rsp_stb_q  <= 1'b1;
                            rsp_word_q <= {2'b10, i_cmd_word[31:0]};
                        end else begin
                            state_q    <= RESP;
                            rsp_stb_q  <= 1'b1;
                            rsp_word_q <= {2'b11, 32'h0000_0002};
                        end
                    end
                end
                BUS_REQ: begin
                    if (timed_out) begin
                        state_q    <= RESP;
                        wb_cyc_q   <= 1'b0;
                        wb_stb_q   <= 1'b0;
                        wb_we_q    <= 1'b0;
                        rsp_stb_q  <= 1'b1;
                        rsp_word_q <= {2'b11, 32'h0000_0001};
                    end else begin
                        timer_q <= timer_d;
                        if (!i_wb_stall) begin
                            state_q  <= BUS_WAIT;
                            wb_stb_q <= 1'b0;
                        end
                    end
                end
                BUS_WAIT: begin
                    // A completed transfer wins over a timeout landing on the same cycle.
                    if (i_wb_err || i_wb_ack || timed_out) begin
                        state_q   <= RESP;
                        wb_cyc_q  <= 1'b0;
                        wb_stb_q  <= 1'b0;
                        wb_we_q   <= 1'b0;
                        rsp_stb_q <= 1'b1;
                        if (i_wb_err) begin
                            rsp_word_q <= {2'b11, 32'h0000_0000};
                        end else if (i_wb_ack) begin
                            addr_q     <= addr_d;
                            rsp_word_q <= wb_we_q ? {2'b01, wb_addr_q} : {2'b00, i_wb_data};
                        end else begin
                            rsp_word_q <= {2'b11, 32'h0000_0001};
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_cmd_busy = (state_q != IDLE);
    assign o_overrun  = overrun_q;
    assign o_wb_cyc   = wb_cyc_q;
    assign o_wb_stb   = wb_stb_q;
    assign o_wb_we    = wb_we_q;
    assign o_wb_addr  = wb_addr_q;
    assign o_wb_data  = wb_data_q;
    assign o_wb_sel   = wb_cyc_q ? 4'hF : 4'h0;
    assign o_rsp_stb  = rsp_stb_q;
    assign o_rsp_word = rsp_word_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - randomized bench for wb_cmd_master against a transaction-level model
module tb_wb_cmd_master;
    localparam int TMO = 8;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_cmd_stb = 1'b0;
    logic [33:0] i_cmd_word = '0;
    logic        o_cmd_busy, o_overrun;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack = 1'b0, i_wb_err = 1'b0, i_wb_stall = 1'b0;
    logic [31:0] i_wb_data = '0;
    logic        o_rsp_stb;
    logic [33:0] o_rsp_word;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_addr = 32'h0;

    wb_cmd_master #(.ADDR_INC(32'd1), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_stb(i_cmd_stb), .i_cmd_word(i_cmd_word),
        .o_cmd_busy(o_cmd_busy), .o_overrun(o_overrun),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_stall(i_wb_stall),
        .i_wb_data(i_wb_data),
        .o_rsp_stb(o_rsp_stb), .o_rsp_word(o_rsp_word)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode: 0 ack, 1 err, 2 ack+err together, 3 never answered
    task automatic run_cmd(input logic [1:0] cmd, input logic [31:0] data, input int stall_n,
                           input int ack_dly, input int mode, input logic [31:0] rdata, input int inj_at);
        logic [33:0] exp_rsp;
        logic [33:0] got_rsp;
        logic [31:0] bus_addr;
        int exp_lat, exp_stb, exp_cyc;
        int lat, stb_cnt, cyc_cnt, wait_cnt, bad_bus, bad_sel, ov_cnt;
        logic busy_at_rsp;
        bit bus;

        bus = (cmd == 2'b00 || cmd == 2'b01);
        bus_addr = m_addr;
        if (!bus) begin
            exp_cyc = 0;
            exp_stb = 0;
            exp_rsp = (cmd == 2'b10) ? {2'b10, data} : {2'b11, 32'h2};
        end else if (mode == 3) begin
            exp_cyc = TMO;
            exp_stb = (stall_n + 1 < TMO) ? stall_n + 1 : TMO;
            exp_rsp = {2'b11, 32'h1};
        end else begin
            exp_cyc = stall_n + ack_dly + 2;
            exp_stb = stall_n + 1;
            if (mode != 0)        exp_rsp = {2'b11, 32'h0};
            else if (cmd == 2'b01) exp_rsp = {2'b01, m_addr};
            else                  exp_rsp = {2'b00, rdata};
        end
        exp_lat = exp_cyc + 1;

        @(negedge i_clk);
        i_cmd_stb  = 1'b1;
        i_cmd_word = {cmd, data};
        lat = 0; stb_cnt = 0; cyc_cnt = 0; wait_cnt = 0;
        bad_bus = 0; bad_sel = 0; ov_cnt = 0; got_rsp = '0; busy_at_rsp = 1'b0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge i_clk);
            i_cmd_stb  = (k == inj_at);
            i_cmd_word = {$urandom_range(3, 0) == 0 ? 2'b10 : 2'b01, $urandom};
            if (o_overrun) ov_cnt++;
            if (o_wb_cyc) begin
                cyc_cnt++;
                if (o_wb_sel != 4'hF) bad_sel++;
                if (o_wb_addr != bus_addr || o_wb_we != (cmd == 2'b01) ||
                    (cmd == 2'b01 && o_wb_data != data)) bad_bus++;
            end else if (o_wb_sel != 4'h0) bad_sel++;
            i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = $urandom;
            if (o_wb_stb) begin
                stb_cnt++;
                i_wb_stall = (stb_cnt <= stall_n);
                i_wb_ack   = $urandom_range(1, 0);
                i_wb_err   = $urandom_range(1, 0);
            end else if (o_wb_cyc) begin
                wait_cnt++;
                if (wait_cnt == ack_dly + 1) begin
                    i_wb_ack = (mode == 0 || mode == 2);
                    i_wb_err = (mode == 1 || mode == 2);
                    i_wb_data = rdata;
                end
            end
            if (o_rsp_stb) begin
                lat = k;
                got_rsp = o_rsp_word;
                busy_at_rsp = o_cmd_busy;
            end
        end
        if (lat == 0) chk("rsp_never_seen", 0, 1);
        @(negedge i_clk);
        i_cmd_stb = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
        if (o_overrun) ov_cnt++;
        chk("rsp_word", got_rsp, exp_rsp);
        chk("rsp_latency", lat, exp_lat);
        chk("stb_cycles", stb_cnt, exp_stb);
        chk("cyc_cycles", cyc_cnt, exp_cyc);
        chk("bus_fields", bad_bus, 0);
        chk("sel", bad_sel, 0);
        chk("busy_in_resp", busy_at_rsp, 1);
        chk("rsp_stb_one_cycle", o_rsp_stb, 0);
        chk("busy_after", o_cmd_busy, 0);
        chk("rsp_hold", o_rsp_word, exp_rsp);
        chk("overrun_pulses", ov_cnt, (inj_at > 0) ? 1 : 0);

        if (cmd == 2'b10) m_addr = data;
        else if (bus && mode == 0) m_addr = m_addr + 32'd1;
    endtask

    initial begin
        logic [1:0] c;
        int st, ad, md, inj, seen_rsp;
        #12;
        chk("rst_cyc", o_wb_cyc, 0);
        chk("rst_outs", {o_wb_stb, o_wb_we, o_wb_sel, o_rsp_stb, o_cmd_busy, o_overrun}, 0);
        chk("rst_bus", {o_wb_addr, o_wb_data}, 0);
        chk("rst_rsp_word", o_rsp_word, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        run_cmd(2'b10, 32'h0000_1000, 0, 0, 0, 0, 0);
        run_cmd(2'b01, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        run_cmd(2'b00, 32'h0, 3, 0, 0, 32'h1234_5678, 0);
        run_cmd(2'b00, 32'h0, 0, 0, 3, 0, 0);
        run_cmd(2'b00, 32'h0, 20, 0, 3, 0, 0);
        run_cmd(2'b01, 32'h5555_AAAA, 1, 1, 0, 0, 0);
        run_cmd(2'b10, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        run_cmd(2'b01, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
        run_cmd(2'b00, 32'h0, 0, 0, 0, 32'hCAFE_0001, 0);
        run_cmd(2'b00, 32'h0, 0, 1, 2, 32'h1111_2222, 0);
        run_cmd(2'b01, 32'h0, 0, 0, 1, 0, 0);
        run_cmd(2'b11, 32'h0, 0, 0, 0, 0, 1);
        run_cmd(2'b00, 32'h0, 1, 2, 0, 32'h7777_8888, 3);

        // Reset while a read waits for its ack.
        @(negedge i_clk);
        i_cmd_stb = 1'b1; i_cmd_word = {2'b00, 32'h0};
        @(negedge i_clk);
        i_cmd_stb = 1'b0;
        @(negedge i_clk);
        chk("pre_rst_wait_cyc", {o_wb_cyc, o_wb_stb}, 2'b10);
        #1 i_rst_n = 1'b0;
        #1 chk("rst_mid_cyc", {o_wb_cyc, o_wb_stb, o_cmd_busy}, 0);
        i_wb_ack = 1'b1;
        seen_rsp = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            if (o_rsp_stb) seen_rsp++;
        end
        i_wb_ack = 1'b0;
        i_rst_n = 1'b1;
        m_addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            if (o_rsp_stb) seen_rsp++;
        end
        chk("rst_no_rsp", seen_rsp, 0);
        run_cmd(2'b01, 32'h1357_9BDF, 0, 0, 0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            c  = 2'($urandom_range(3, 0));
            st = $urandom_range(3, 0);
            ad = $urandom_range(2, 0);
            md = $urandom_range(9, 0);
            md = (md < 6) ? 0 : md - 6;
            inj = ($urandom_range(5, 0) == 0) ? 1 : 0;
            if (inj != 0) inj = (c[1] == 1'b1) ? 1 : $urandom_range(st + ad + 3, 1);
            run_cmd(c, ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFE : $urandom, st, ad, md, $urandom, inj);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=%0d", 0, 1);
        $fatal(1);
    end
endmodule
